// File: rtl/mch_tx_frame.sv
// mch_tx_frame: Manchester frame transmitter sending preamble, SOF, LEN and payload, MSB first.
// Define MCH_TX_CRC8_EN to append a CRC-8 (poly 0x07, init 0) computed over LEN and payload.
module mch_tx_frame #(
    parameter int         MAX_BYTES = 4,
    parameter int         HALF_CLKS = 5000,
    parameter int         PRE_BYTES = 2,
    parameter logic [7:0] SOF       = 8'h7E
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             len,
    input  logic [8*MAX_BYTES-1:0] pd,
    output logic                   txsd,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int         TMR_W    = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;
    localparam int         CNT_MAX  = (MAX_BYTES > PRE_BYTES) ? MAX_BYTES : PRE_BYTES;
    localparam int         BYTE_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [7:0] PRE_BYTE = 8'h55;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SOF,
        S_LEN,
        S_DATA,
`ifdef MCH_TX_CRC8_EN
        S_CRC,
`endif
        S_END
    } state_t;

    state_t                 state_q;
    logic [TMR_W-1:0]       tmr_q;
    logic                   phase_q;
    logic [2:0]             bit_q;
    logic [BYTE_W-1:0]      byte_q;
    logic [7:0]             sh_q;
    logic [7:0]             len_q;
    logic [8*MAX_BYTES-1:0] pd_q;
    logic                   txsd_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
`ifdef MCH_TX_CRC8_EN
    logic [7:0]             crc_q;
    logic [7:0]             crc_d;
`endif

    logic              idle_like;
    logic              len_ok;
    logic              half_end;
    logic              bit_end;
    logic              byte_end;
    logic              last_pre;
    logic              last_data;
    logic [BYTE_W-1:0] data_idx;
    state_t            state_d;
    logic [7:0]        byte_d;
    logic [BYTE_W-1:0] byte_cnt_d;

    // END behaves like IDLE for accept/reject so a held start chains frames with a 1-cycle gap.
    always_comb begin
        idle_like = (state_q == S_IDLE) || (state_q == S_END);
        len_ok    = (len != 8'd0) && (len <= 8'(MAX_BYTES));
        half_end  = (tmr_q == TMR_W'(HALF_CLKS - 1));
        bit_end   = half_end && phase_q;
        byte_end  = bit_end && (bit_q == 3'd7);
        last_pre  = (byte_q == BYTE_W'(PRE_BYTES - 1));
        last_data = (8'(byte_q) == (len_q - 8'd1));
        data_idx  = byte_q + 1'b1;
    end

`ifdef MCH_TX_CRC8_EN
    // Bit-serial CRC step for the bit currently on the line (sh_q[7]).
    always_comb begin
        crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ sh_q[7]) ? 8'h07 : 8'h00);
    end
`endif

    // Field sequencing: what goes on the line after the current byte finishes.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        byte_d     = PRE_BYTE;
        byte_cnt_d = byte_q;
        case (state_q)
            S_PRE: begin
                if (last_pre) begin
                    state_d    = S_SOF;
                    byte_d     = SOF;
                    byte_cnt_d = '0;
                end else begin
                    byte_cnt_d = byte_q + 1'b1;
                end
            end
            S_SOF: begin
                state_d = S_LEN;
                byte_d  = len_q;
            end
            S_LEN: begin
                state_d    = S_DATA;
                byte_d     = pd_q[7:0];
                byte_cnt_d = '0;
            end
            S_DATA: begin
                if (last_data) begin
`ifdef MCH_TX_CRC8_EN
                    state_d = S_CRC;
                    byte_d  = crc_d;
`else
                    state_d = S_END;
`endif
                end else begin
                    byte_cnt_d = data_idx;
                    byte_d     = pd_q[8*data_idx +: 8];
                end
            end
`ifdef MCH_TX_CRC8_EN
            S_CRC: state_d = S_END;
`endif
            default: ;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            pd_q    <= '0;
            txsd_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MCH_TX_CRC8_EN
            crc_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (idle_like) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                txsd_q  <= 1'b1;
                if (start) begin
                    if (len_ok) begin
                        state_q <= S_PRE;
                        busy_q  <= 1'b1;
                        len_q   <= len;
                        pd_q    <= pd;
                        sh_q    <= PRE_BYTE;
                        tmr_q   <= '0;
                        phase_q <= 1'b0;
                        bit_q   <= '0;
                        byte_q  <= '0;
                        txsd_q  <= ~PRE_BYTE[7];
`ifdef MCH_TX_CRC8_EN
                        crc_q   <= '0;
`endif
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end else begin
                tmr_q <= half_end ? '0 : tmr_q + 1'b1;
                if (half_end && !phase_q) begin
                    phase_q <= 1'b1;
                    txsd_q  <= sh_q[7];
                end else if (bit_end) begin
                    phase_q <= 1'b0;
                    bit_q   <= bit_q + 3'd1;
`ifdef MCH_TX_CRC8_EN
                    if (state_q == S_LEN || state_q == S_DATA) begin
                        crc_q <= crc_d;
                    end
`endif
                    if (byte_end) begin
                        state_q <= state_d;
                        byte_q  <= byte_cnt_d;
                        sh_q    <= byte_d;
                        if (state_d == S_END) begin
                            txsd_q <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            txsd_q <= ~byte_d[7];
                        end
                    end else begin
                        sh_q   <= {sh_q[6:0], 1'b0};
                        txsd_q <= ~sh_q[6];
                    end
                end
            end
        end
    end

    assign txsd = txsd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mch_tx_frame.sv
// Self-checking bench for mch_tx_frame: vector table plus hand sequences, with a Manchester
// receiver model popping expected bytes from a scoreboard queue.
module tb_mch_tx_frame;

    localparam int         MAX_BYTES = 4;
    localparam int         HALF_CLKS = 4;
    localparam int         PRE_BYTES = 2;
    localparam logic [7:0] SOF_BYTE  = 8'h7E;
`ifdef MCH_TX_CRC8_EN
    localparam int         CRC_BYTES = 1;
`else
    localparam int         CRC_BYTES = 0;
`endif
    localparam int         BUDGET    = (PRE_BYTES + 2 + MAX_BYTES + 1) * 16 * HALF_CLKS + 50;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len   = 8'd0;
    logic [31:0] pd    = 32'd0;
    logic        txsd;
    logic        busy;
    logic        done;
    logic        err;

    mch_tx_frame #(
        .MAX_BYTES(MAX_BYTES),
        .HALF_CLKS(HALF_CLKS),
        .PRE_BYTES(PRE_BYTES),
        .SOF      (SOF_BYTE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .len  (len),
        .pd   (pd),
        .txsd (txsd),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         err_cnt  = 0;
    int         done_cnt = 0;
    int         viol_cnt = 0;

    typedef struct {
        logic [7:0]  len;
        logic [31:0] pd;
        logic        exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t vec[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] l, input logic [31:0] p);
        logic [7:0] crc;
        logic [7:0] b;
        for (int i = 0; i < PRE_BYTES; i++) exp_q.push_back(8'h55);
        exp_q.push_back(SOF_BYTE);
        exp_q.push_back(l);
        crc = crc8_byte(8'h00, l);
        for (int i = 0; i < int'(l); i++) begin
            b = p[8*i +: 8];
            exp_q.push_back(b);
            crc = crc8_byte(crc, b);
        end
        if (CRC_BYTES != 0) exp_q.push_back(crc);
        exp_cyc_q.push_back((PRE_BYTES + 2 + int'(l) + CRC_BYTES) * 16 * HALF_CLKS);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] l, input logic [31:0] p);
        push_frame(l, p);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        pd    = p;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        wait_done(BUDGET);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
    endtask

    // Receiver model: samples the middle of each half-bit, decodes the second half as the bit.
    initial begin
        int         cyc;
        bit         active;
        logic       h0;
        logic [7:0] sh;
        int         nbits;
        active = 1'b0;
        cyc    = 0;
        h0     = 1'b0;
        sh     = 8'd0;
        nbits  = 0;
        forever begin
            @(negedge clk);
            if (err === 1'b1) err_cnt++;
            if (done === 1'b1) done_cnt++;
            if (rst !== 1'b1) begin
                active = 1'b0;
            end else begin
                if (!active && busy === 1'b1) begin
                    active = 1'b1;
                    cyc    = 0;
                    nbits  = 0;
                end
                if (active) begin
                    if (done === 1'b1) begin
                        if (exp_cyc_q.size() == 0) check("frame_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                        else check("frame_cycles", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                        check("busy_low_at_done", busy, 1'b0);
                        check("txsd_high_at_done", txsd, 1'b1);
                        active = 1'b0;
                    end else begin
                        if (cyc % HALF_CLKS == HALF_CLKS / 2) begin
                            if (((cyc / HALF_CLKS) % 2) == 0) begin
                                h0 = txsd;
                            end else begin
                                if (h0 === txsd) viol_cnt++;
                                sh = {sh[6:0], txsd};
                                nbits++;
                                if (nbits % 8 == 0) begin
                                    if (exp_q.size() == 0) check("rx_unexpected_byte", 32'(sh), 32'h100);
                                    else check("rx_byte", 32'(sh), 32'(exp_q.pop_front()));
                                end
                            end
                        end
                        cyc++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int d0;

        vec[0] = '{len: 8'd1, pd: 32'h0000_00A3, exp_busy: 1'b1, exp_err: 1'b0};
        vec[1] = '{len: 8'd4, pd: 32'h3332_3130, exp_busy: 1'b1, exp_err: 1'b0};
        vec[2] = '{len: 8'd0, pd: 32'h1234_5678, exp_busy: 1'b0, exp_err: 1'b1};
        vec[3] = '{len: 8'd5, pd: 32'h1234_5678, exp_busy: 1'b0, exp_err: 1'b1};
        vec[4] = '{len: 8'd3, pd: 32'h11C0_FFEE, exp_busy: 1'b1, exp_err: 1'b0};
        vec[5] = '{len: 8'd2, pd: 32'h0000_00FF, exp_busy: 1'b1, exp_err: 1'b0};

        // Reset state
        #3 rst = 1'b0;
        #2;
        check("reset_txsd", txsd, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven accept/reject vectors
        for (int i = 0; i < 6; i++) begin
            if (vec[i].exp_busy) push_frame(vec[i].len, vec[i].pd);
            @(negedge clk);
            start = 1'b1;
            len   = vec[i].len;
            pd    = vec[i].pd;
            @(negedge clk);
            start = 1'b0;
            check("busy_after_start", busy, vec[i].exp_busy);
            check("err_after_start", err, vec[i].exp_err);
            check("txsd_after_start", txsd, 1'b1);
            @(negedge clk);
            check("err_one_cycle", err, 1'b0);
            if (vec[i].exp_busy) begin
                wait_done(BUDGET);
                @(negedge clk);
                check("done_one_cycle", done, 1'b0);
                check("busy_low_after_done", busy, 1'b0);
            end else begin
                check("reject_busy_low", busy, 1'b0);
                check("reject_txsd_high", txsd, 1'b1);
            end
            repeat (3) @(negedge clk);
        end

        // start pulsed mid-frame with new pd/len: ignored, no err
        push_frame(8'd2, 32'h0000_BEEF);
        e0 = err_cnt;
        @(negedge clk);
        start = 1'b1;
        len   = 8'd2;
        pd    = 32'h0000_BEEF;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1;
        len   = 8'd1;
        pd    = 32'hDEAD_DEAD;
        @(negedge clk);
        start = 1'b0;
        wait_done(BUDGET);
        check("no_err_while_busy", 32'(err_cnt - e0), 32'd0);
        repeat (3) @(negedge clk);

        // Reset during DATA bit 3 aborts the frame without done
        push_frame(8'd4, 32'h8765_4321);
        @(negedge clk);
        start = 1'b1;
        len   = 8'd4;
        pd    = 32'h8765_4321;
        @(negedge clk);
        start = 1'b0;
        repeat ((PRE_BYTES + 2) * 16 * HALF_CLKS + 6 * HALF_CLKS + 2) @(negedge clk);
        check("busy_before_abort", busy, 1'b1);
        d0 = done_cnt;
        #1 rst = 1'b0;
        #1;
        check("abort_txsd_async", txsd, 1'b1);
        check("abort_busy_async", busy, 1'b0);
        exp_q.delete();
        exp_cyc_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_stays_idle", busy, 1'b0);
        run_frame(8'd3, 32'h00A5_5A0F);
        repeat (3) @(negedge clk);

        // start held across two frames: second preamble one cycle after done
        push_frame(8'd2, 32'h0000_C3A5);
        push_frame(8'd2, 32'h0000_C3A5);
        @(negedge clk);
        start = 1'b1;
        len   = 8'd2;
        pd    = 32'h0000_C3A5;
        wait_done(BUDGET);
        @(negedge clk);
        check("b2b_busy_after_done", busy, 1'b1);
        check("b2b_done_low", done, 1'b0);
        start = 1'b0;
        wait_done(BUDGET);
        @(negedge clk);
        check("b2b_done_one_cycle", done, 1'b0);
        check("b2b_idle", busy, 1'b0);
        repeat (5) @(negedge clk);

        check("scoreboard_bytes_left", 32'(exp_q.size()), 32'd0);
        check("scoreboard_frames_left", 32'(exp_cyc_q.size()), 32'd0);
        check("manchester_violations", 32'(viol_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
